// File: rtl/ui_input_responder_if.sv
// ui_input_responder_if
//   IO-bus view of the input responder, as seen between the IO controller
//   (master) and the responder (slave).
//
//   Handshake: rdEn and wrtEn are single-cycle strobes with no back-pressure.
//   The responder is always ready: a load or store is accepted on the rising
//   edge where its strobe is high. dataOut and hit are combinational from addr
//   and the current register state, so read data is valid in the same cycle
//   as the load strobe, before the edge that applies any read side effect.
//
//   Signals:
//     addr    master -> slave  bus address
//     rdEn    master -> slave  load strobe
//     wrtEn   master -> slave  store strobe
//     dataIn  master -> slave  store data
//     dataOut slave -> master  read data
//     hit     slave -> master  address decodes to one of this block's registers
interface ui_input_responder_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             rdEn;
    logic             wrtEn;
    logic [DBITS-1:0] dataIn;
    logic [DBITS-1:0] dataOut;
    logic             hit;

    modport master (
        output addr, rdEn, wrtEn, dataIn,
        input  dataOut, hit
    );

    modport slave (
        input  addr, rdEn, wrtEn, dataIn,
        output dataOut, hit
    );
endinterface

// File: rtl/ui_input_responder.sv
// ui_input_responder
//   Memory-mapped responder for the board keys and switches. Raw pins are
//   synchronized (two flops), debounced with one shared counter per device
//   group, and turned into sticky ready/overrun status with a per-device
//   interrupt enable.
//
//   Ports:
//     clk      system clock, all state on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      IO bus slave (addr, rdEn, wrtEn, dataIn, dataOut, hit)
//     KEY      raw keys, active-low (pressed = 0)
//     SW       raw switches
//     irq      (kready & kie) | (sready & sie)
//
//   Register map:
//     ADDR_KEY    KDATA  = ~keyStable in [3:0]; a load clears kready
//     ADDR_SW     SDATA  = swStable in [9:0];   a load clears sready
//     ADDR_KCTRL  {ie[8], over[2], ready[0]}; store may clear ready/over, sets ie
//     ADDR_SCTRL  same layout for the switches
module ui_input_responder #(
    parameter int                 DBITS           = 32,
    parameter logic [DBITS-1:0]   ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0]   ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0]   ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0]   ADDR_SCTRL      = 32'hF0000114,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 CNT_BITS        = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ui_input_responder_if.slave   bus,
    input  logic [3:0]            KEY,
    input  logic [9:0]            SW,
    output logic                  irq
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    // Key group: resets to all-released (1s) so no spurious press at startup.
    logic [3:0]          keyS1, keyS2, keyPrev, keyStable;
    logic [CNT_BITS-1:0] keyCnt;
    // Switch group.
    logic [9:0]          swS1, swS2, swPrev, swStable;
    logic [CNT_BITS-1:0] swCnt;

    logic kready, kover, kie;
    logic sready, sover, sie;

    // Address decode.
    logic selKey, selSw, selKctrl, selSctrl;
    assign selKey   = (bus.addr == ADDR_KEY);
    assign selSw    = (bus.addr == ADDR_SW);
    assign selKctrl = (bus.addr == ADDR_KCTRL);
    assign selSctrl = (bus.addr == ADDR_SCTRL);

    // ------------------------------------------------------------------
    // Debounce. The counter only advances while the synchronized value has
    // held still for a cycle and differs from the accepted value; any
    // movement restarts it. The accept condition is exported so the event
    // is raised on the same edge that updates the stable value.
    // ------------------------------------------------------------------
    logic keyAccept, swAccept;
    assign keyAccept = (keyS2 == keyPrev) && (keyS2 != keyStable) && (keyCnt == CNT_MAX);
    assign swAccept  = (swS2 == swPrev) && (swS2 != swStable) && (swCnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyS1     <= 4'hF;
            keyS2     <= 4'hF;
            keyPrev   <= 4'hF;
            keyStable <= 4'hF;
            keyCnt    <= '0;
        end else begin
            keyS1   <= KEY;
            keyS2   <= keyS1;
            keyPrev <= keyS2;
            if ((keyS2 != keyPrev) || (keyS2 == keyStable)) begin
                keyCnt <= '0;
            end else if (keyCnt == CNT_MAX) begin
                keyStable <= keyS2;
                keyCnt    <= '0;
            end else begin
                keyCnt <= keyCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swS1     <= '0;
            swS2     <= '0;
            swPrev   <= '0;
            swStable <= '0;
            swCnt    <= '0;
        end else begin
            swS1   <= SW;
            swS2   <= swS1;
            swPrev <= swS2;
            if ((swS2 != swPrev) || (swS2 == swStable)) begin
                swCnt <= '0;
            end else if (swCnt == CNT_MAX) begin
                swStable <= swS2;
                swCnt    <= '0;
            end else begin
                swCnt <= swCnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Events: a key event is a new press only (stable bit 1 -> 0);
    // any accepted switch change is a switch event.
    // ------------------------------------------------------------------
    logic kev, sev;
    assign kev = keyAccept && (|(keyStable & ~keyS2));
    assign sev = swAccept;

    // Clear sources: reading the data register, or a control store with
    // bit 0 low. Over is cleared only by a control store with bit 2 low.
    logic kclr, sclr, kctrlWr, sctrlWr, koverClr, soverClr;
    assign kctrlWr  = bus.wrtEn && selKctrl;
    assign sctrlWr  = bus.wrtEn && selSctrl;
    assign kclr     = (bus.rdEn && selKey) || (kctrlWr && !bus.dataIn[0]);
    assign sclr     = (bus.rdEn && selSw)  || (sctrlWr && !bus.dataIn[0]);
    assign koverClr = kctrlWr && !bus.dataIn[2];
    assign soverClr = sctrlWr && !bus.dataIn[2];

    // An event always wins over a same-cycle clear; over is only set when an
    // unconsumed ready is overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kready <= 1'b0;
            kover  <= 1'b0;
            kie    <= 1'b0;
            sready <= 1'b0;
            sover  <= 1'b0;
            sie    <= 1'b0;
        end else begin
            kready <= kev || (kready && !kclr);
            kover  <= (kev && kready && !kclr) || (kover && !koverClr);
            sready <= sev || (sready && !sclr);
            sover  <= (sev && sready && !sclr) || (sover && !soverClr);
            if (kctrlWr) kie <= bus.dataIn[8];
            if (sctrlWr) sie <= bus.dataIn[8];
        end
    end

    assign irq = (kready && kie) || (sready && sie);

    // ------------------------------------------------------------------
    // Read mux.
    // ------------------------------------------------------------------
    logic [DBITS-1:0] rdData;

    always_comb begin
        rdData = '0;
        if (selKey) begin
            rdData[3:0] = ~keyStable;
        end else if (selSw) begin
            rdData[9:0] = swStable;
        end else if (selKctrl) begin
            rdData[8] = kie;
            rdData[2] = kover;
            rdData[0] = kready;
        end else if (selSctrl) begin
            rdData[8] = sie;
            rdData[2] = sover;
            rdData[0] = sready;
        end
    end

    assign bus.dataOut = rdData;
    assign bus.hit     = selKey || selSw || selKctrl || selSctrl;

endmodule
